// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and writeback entry type for the regfile writer
package regfile_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;

  typedef struct packed {
    logic [RF_ADDR_WIDTH-1:0] addr;
    logic [RF_DATA_WIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - circular writeback queue with per-entry valid bits
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  entry_t                push_entry,
  input  logic                  pop,
  output entry_t                head_entry,
  output entry_t [DEPTH-1:0]    entries,
  output logic   [DEPTH-1:0]    valid,
  output logic   [PTR_W-1:0]    head_ptr,
  output logic   [CNT_W-1:0]    count,
  output logic                  full,
  output logic                  empty
);

  entry_t [DEPTH-1:0] mem;
  logic   [PTR_W-1:0] tail_ptr;

  // Payload storage carries no reset; the valid bits alone define occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      valid    <= '0;
    end else begin
      if (push) begin
        valid[tail_ptr] <= 1'b1;
        tail_ptr        <= tail_ptr + 1'b1;
      end
      if (pop) begin
        valid[head_ptr] <= 1'b0;
        head_ptr        <= head_ptr + 1'b1;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head_entry = mem[head_ptr];
  assign entries    = mem;
  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);

endmodule

// File: rtl/regfile_writer.sv
// rtl/regfile_writer.sv - arbitrates LSU/ALU writebacks into a queue feeding the register file
module regfile_writer
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [ADDR_WIDTH-1:0]      lsu_addr,
  input  logic [DATA_WIDTH-1:0]      lsu_data,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [ADDR_WIDTH-1:0]      alu_addr,
  input  logic [DATA_WIDTH-1:0]      alu_data,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  input  logic                       rf_hold,
  input  logic [ADDR_WIDTH-1:0]      query_addr,
  output logic                       query_hit,
  output logic [DATA_WIDTH-1:0]      query_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t               in_entry;
  entry_t               head_entry;
  entry_t [DEPTH-1:0]   entries;
  logic   [DEPTH-1:0]   valid;
  logic   [PTR_W-1:0]   head_ptr;
  logic                 accept_lsu;
  logic                 accept_alu;
  logic                 push;

  // Ready looks only at the registered full flag, so a same-cycle pop never frees a slot.
  assign lsu_ready  = !full;
  assign alu_ready  = !full && !lsu_valid;
  assign accept_lsu = lsu_valid && lsu_ready;
  assign accept_alu = alu_valid && alu_ready;

  always_comb begin
    in_entry = '0;
    if (accept_lsu) begin
      in_entry.addr = lsu_addr;
      in_entry.data = lsu_data;
    end else if (accept_alu) begin
      in_entry.addr = alu_addr;
      in_entry.data = alu_data;
    end
  end

  // Writes to x0 finish the handshake but are dropped here.
  assign push = (accept_lsu || accept_alu) && (in_entry.addr != '0);

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (in_entry),
    .pop        (rf_wen),
    .head_entry (head_entry),
    .entries    (entries),
    .valid      (valid),
    .head_ptr   (head_ptr),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  assign rf_wen   = !empty && !rf_hold;
  assign rf_waddr = empty ? '0 : head_entry.addr;
  assign rf_wdata = empty ? '0 : head_entry.data;

  // Walk oldest to youngest so the last match found is the youngest one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx        = '0;
    query_hit  = 1'b0;
    query_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PTR_W'(i);
      if (valid[idx] && (query_addr != '0) && (entries[idx].addr == query_addr)) begin
        query_hit  = 1'b1;
        query_data = entries[idx].data;
      end
    end
  end

endmodule

// File: doc/regfile_writer.md
REGFILE_WRITER -- requirements
Module: regfile_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, meaning register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning register data width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning write-queue entries; power of two and at least 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports lsu_valid in 1, lsu_ready out 1, lsu_addr in ADDR_WIDTH, lsu_data in DATA_WIDTH: the load-unit writeback request.
REQ-007 SHALL have ports alu_valid in 1, alu_ready out 1, alu_addr in ADDR_WIDTH, alu_data in DATA_WIDTH: the ALU writeback request.
REQ-008 SHALL have ports rf_wen out 1, rf_waddr out ADDR_WIDTH, rf_wdata out DATA_WIDTH, which drive the register-file write port.
REQ-009 SHALL have port rf_hold  input  1  which, when 1, blocks draining to the register file.
REQ-010 SHALL have ports query_addr in ADDR_WIDTH, query_hit out 1, query_data out DATA_WIDTH: the operand-forwarding lookup.
REQ-011 SHALL have ports full out 1, empty out 1, count out $clog2(DEPTH)+1.

Function
REQ-012 A request SHALL be accepted on a rising edge when its valid and ready are both 1.
REQ-013 lsu_ready SHALL equal !full.
REQ-014 alu_ready SHALL equal !full && !lsu_valid; LSU has fixed priority and at most one request is accepted per cycle.
REQ-015 Ready SHALL NOT depend on a same-cycle pop, so there is no pass-through when the queue is full.
REQ-016 An accepted request with addr == 0 SHALL complete its handshake and be discarded; it is not enqueued and count is unchanged.
REQ-017 An accepted nonzero request SHALL be written at the tail, after which the tail pointer increments modulo DEPTH.
REQ-018 rf_wen SHALL equal !empty && !rf_hold; rf_waddr/rf_wdata SHALL be driven combinationally from the head entry, and SHALL be 0 when empty.
REQ-019 When rf_wen=1, the head SHALL pop on that edge (register file writes the same edge); the head pointer then wraps modulo DEPTH.
REQ-020 Enqueue-to-write latency SHALL be: entry accepted at edge N is presented at cycle N+1 and committed at edge N+1 when it is at the head and rf_hold=0.
REQ-021 Simultaneous enqueue and pop SHALL leave count unchanged; count SHALL stay in 0..DEPTH; full = (count==DEPTH); empty = (count==0).
REQ-022 Writes SHALL reach the register file in acceptance order; back-to-back writes to the same address SHALL all be issued, with no coalescing.
REQ-023 query_hit SHALL be 1 iff query_addr != 0 and any valid entry (head included) matches it.
REQ-024 query_data SHALL be the data of the youngest matching entry, or 0 when query_hit=0.
REQ-025 The query SHALL be purely combinational on current queue state; same-cycle incoming requests SHALL NOT be visible to it.
REQ-026 rf_hold=1 with the queue full SHALL stall both producers (ready=0) indefinitely without loss of data.

Reset
REQ-027 rst=1 SHALL immediately clear head/tail pointers, count, and all entry valid bits.
REQ-028 During reset the outputs SHALL be: rf_wen=0, rf_waddr=0, rf_wdata=0, empty=1, full=0, count=0, query_hit=0, ready outputs=1.
REQ-029 Reset asserted mid-operation SHALL drop all queued writes; none SHALL be issued after release.
REQ-030 Entry data storage need not be reset.

Structure
REQ-031 A shared package regfile_pkg SHALL hold ADDR_WIDTH/DATA_WIDTH defaults and the entry type wb_entry_t {addr, data}.
REQ-032 A single sub-module wb_fifo SHALL hold the storage, pointers and count; the arbitration, x0 filter and forwarding match SHALL live in regfile_writer.

Verification
REQ-033 Single write: lsu addr=3 data=0xDEADBEEF, accepted at edge 0 -> cycle 1 shows rf_wen=1, waddr=3, wdata=0xDEADBEEF; empty=1 after edge 1.
REQ-034 Contention: lsu (5, 0x11) and alu (6, 0x22) valid in the same cycle -> alu_ready=0; rf sees addr 5 then addr 6 on consecutive cycles.
REQ-035 x0 filter: alu addr=0 data=0xFFFF_FFFF -> alu_ready=1 and handshake completes; count stays 0; rf_wen never asserts.
REQ-036 Full/hold: rf_hold=1 with writes to 1,2,3,4 -> count=4, full=1, both ready=0; a 5th request is held; releasing hold drains 1,2,3,4 then the 5th, in order.
REQ-037 Forwarding: with rf_hold=1, queue (7,0xA) then (7,0xB), query_addr=7 -> query_hit=1, query_data=0xB; query_addr=0 -> hit=0, data=0.
REQ-038 Reset mid-operation: 3 entries queued, rst pulsed asynchronously mid-cycle -> rf_wen=0 immediately, count=0, and no stale write is issued after release.
